// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accumulate/requantise/ReLU output stage.
package conv_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int SHIFT_W = 4;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN,
    OUT
  } state_e;

endpackage

// File: rtl/conv_acc_relu_if.sv
// Upstream partial-sum stream and downstream activation handshake of conv_acc_relu.
interface conv_acc_relu_if #(
  parameter int pDATA_W = conv_pkg::DATA_W,
  parameter int pACC_W  = conv_pkg::ACC_W
);

  logic                        ivalid;
  logic                        ilast;
  logic signed [2*pDATA_W-1:0] idata;
  logic signed [pACC_W-1:0]    ibias;
  logic [conv_pkg::SHIFT_W-1:0] ishift;
  logic                        ordy;
  logic                        ovalid;
  logic                        iready;
  logic [pDATA_W-1:0]          odata;
  logic                        oovf;

  modport slave (
    input  ivalid, ilast, idata, ibias, ishift, iready,
    output ordy, ovalid, odata, oovf
  );

  modport master (
    output ivalid, ilast, idata, ibias, ishift, iready,
    input  ordy, ovalid, odata, oovf
  );

endinterface

// File: rtl/requant_relu.sv
// Arithmetic right shift of the accumulator, then ReLU and clamp to the unsigned pixel range.
module requant_relu
  import conv_pkg::*;
#(
  parameter int pDATA_W = DATA_W,
  parameter int pACC_W  = ACC_W
) (
  input  logic signed [pACC_W-1:0]  acc,
  input  logic [SHIFT_W-1:0]        shift,
  output logic [pDATA_W-1:0]        value
);

  logic signed [pACC_W-1:0] shifted;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = acc >>> shift;
    value   = shifted[pDATA_W-1:0];
    if (shifted[pACC_W-1]) begin
      value = '0;
    end else if (|shifted[pACC_W-2:pDATA_W]) begin
      value = '1;
    end
  end

endmodule

// File: rtl/conv_acc_relu.sv
// Accumulates a group of signed partial sums onto a bias with saturation, then emits one
// requantised ReLU pixel through a valid/ready handshake.
module conv_acc_relu
  import conv_pkg::*;
#(
  parameter int pDATA_W = DATA_W,
  parameter int pACC_W  = ACC_W
) (
  input  logic           iclk,
  input  logic           irst_n,
  conv_acc_relu_if.slave bus
);

  localparam logic signed [pACC_W-1:0] SAT_MAX = {1'b0, {(pACC_W-1){1'b1}}};
  localparam logic signed [pACC_W-1:0] SAT_MIN = {1'b1, {(pACC_W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic signed [pACC_W-1:0] acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d;
  logic                     ovalid_q, ovalid_d;
  logic [pDATA_W-1:0]       odata_q, odata_d;
  logic                     oovf_q, oovf_d;

  logic                     ordy;
  logic                     beat;
  logic signed [pACC_W-1:0] add_a;
  logic [pACC_W:0]          sum_w;
  logic                     sat_hit;
  logic signed [pACC_W-1:0] sat_sum;
  logic [pDATA_W-1:0]       relu_val;

  assign ordy = (state_q == IDLE) || (state_q == ACC);
  assign beat = bus.ivalid && ordy;

  // The first beat adds onto the bias, later beats onto the running accumulator.
  always_comb begin
    add_a   = (state_q == IDLE) ? bus.ibias : acc_q;
    sum_w   = {add_a[pACC_W-1], add_a}
            + {{(pACC_W+1-2*pDATA_W){bus.idata[2*pDATA_W-1]}}, bus.idata};
    sat_hit = sum_w[pACC_W] ^ sum_w[pACC_W-1];
    sat_sum = sum_w[pACC_W-1:0];
    if (sat_hit) begin
      sat_sum = sum_w[pACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

  requant_relu #(
    .pDATA_W (pDATA_W),
    .pACC_W  (pACC_W)
  ) u_requant_relu (
    .acc   (acc_q),
    .shift (shift_q),
    .value (relu_val)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    shift_d  = shift_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    oovf_d   = oovf_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = sat_sum;
          shift_d = bus.ishift;
          ovf_d   = sat_hit;
          state_d = bus.ilast ? FIN : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d   = sat_sum;
          ovf_d   = ovf_q | sat_hit;
          state_d = bus.ilast ? FIN : ACC;
        end
      end
      FIN: begin
        odata_d  = relu_val;
        oovf_d   = ovf_q;
        ovalid_d = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.iready) begin
          ovalid_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      oovf_q   <= oovf_d;
    end
  end

  assign bus.ordy   = ordy;
  assign bus.ovalid = ovalid_q;
  assign bus.odata  = odata_q;
  assign bus.oovf   = oovf_q;

endmodule

// File: tb/tb_conv_acc_relu.sv
// Randomised and directed checks of conv_acc_relu against an integer reference model.
module tb_conv_acc_relu;
  import conv_pkg::*;

  logic iclk;
  logic irst_n;

  conv_acc_relu_if bus ();

  conv_acc_relu dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Group under test: bias, shift, beats, output wait cycles, hold a beat on the bus while blocked.
  logic signed [23:0] g_bias;
  logic [3:0]         g_shift;
  logic signed [15:0] g_beats [8];
  int                 g_n;
  int                 g_wait;
  bit                 g_hold;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic longint clamp_acc(input longint v, inout bit ovf);
    if (v > longint'(ACC_MAX)) begin
      ovf = 1'b1;
      return longint'(ACC_MAX);
    end
    if (v < longint'(ACC_MIN)) begin
      ovf = 1'b1;
      return longint'(ACC_MIN);
    end
    return v;
  endfunction

  task automatic idle_bus();
    bus.ivalid = 1'b0;
    bus.ilast  = 1'b0;
    bus.idata  = '0;
    bus.ibias  = '0;
    bus.ishift = '0;
    bus.iready = 1'b0;
  endtask

  task automatic run_group();
    longint acc;
    longint res;
    bit     ovf;
    logic [7:0] exp_data;
    logic [7:0] held;

    ovf = 1'b0;
    acc = longint'(g_bias);
    for (int i = 0; i < g_n; i++) acc = clamp_acc(acc + longint'(g_beats[i]), ovf);
    res = acc >>> g_shift;
    exp_data = (res < 0) ? 8'd0 : (res > 255) ? 8'd255 : res[7:0];

    for (int i = 0; i < g_n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.ivalid = 1'b0;
        bus.ilast  = 1'($urandom);
        bus.idata  = 16'($urandom);
        bus.iready = 1'($urandom);
        tick();
      end
      bus.ivalid = 1'b1;
      bus.idata  = g_beats[i];
      bus.ilast  = (i == g_n - 1);
      bus.ibias  = (i == 0) ? g_bias : 24'($urandom);
      bus.ishift = (i == 0) ? g_shift : 4'($urandom);
      bus.iready = 1'($urandom);
      check("ordy_accept", bus.ordy, 1);
      tick();
    end

    bus.ivalid = g_hold;
    bus.idata  = 16'sd7;
    bus.ilast  = 1'($urandom);
    bus.iready = 1'($urandom);
    check("fin_ovalid", bus.ovalid, 0);
    check("fin_ordy", bus.ordy, 0);
    tick();
    check("out_ovalid", bus.ovalid, 1);
    check("out_odata", bus.odata, exp_data);
    check("out_oovf", bus.oovf, ovf);
    held = bus.odata;

    bus.iready = (g_wait == 0);
    for (int w = 0; w < g_wait; w++) begin
      tick();
      check("wait_ovalid", bus.ovalid, 1);
      check("wait_odata", bus.odata, held);
      check("wait_ordy", bus.ordy, 0);
      if (w == g_wait - 1) bus.iready = 1'b1;
    end
    tick();
    check("done_ovalid", bus.ovalid, 0);
    check("done_ordy", bus.ordy, 1);
    idle_bus();
  endtask

  task automatic set_group(input logic signed [23:0] bias, input logic [3:0] shift,
                           input int n, input int wait_c, input bit hold);
    g_bias  = bias;
    g_shift = shift;
    g_n     = n;
    g_wait  = wait_c;
    g_hold  = hold;
  endtask

  initial begin
    idle_bus();
    irst_n = 1'b0;
    tick();
    tick();
    check("rst_ovalid", bus.ovalid, 0);
    check("rst_odata", bus.odata, 0);
    check("rst_oovf", bus.oovf, 0);
    check("rst_ordy", bus.ordy, 1);
    irst_n = 1'b1;
    tick();

    set_group(24'sd10, 4'd1, 3, 0, 1'b0);
    g_beats[0] = 16'sd100; g_beats[1] = 16'sd200; g_beats[2] = -16'sd50;
    run_group();

    set_group(24'sd0, 4'd0, 1, 0, 1'b0);
    g_beats[0] = -16'sd300;
    run_group();

    set_group(24'sd0, 4'd0, 1, 0, 1'b0);
    g_beats[0] = 16'sd1000;
    run_group();

    set_group(24'sh7FFF00, 4'd0, 2, 0, 1'b0);
    g_beats[0] = 16'sd32767; g_beats[1] = 16'sd32767;
    run_group();

    set_group(24'sd20, 4'd0, 2, 5, 1'b1);
    g_beats[0] = 16'sd3; g_beats[1] = 16'sd4;
    run_group();

    // Reset mid-group discards the partial sum.
    bus.ivalid = 1'b1; bus.ilast = 1'b0; bus.ibias = '0; bus.ishift = '0;
    bus.idata  = 16'sd50;
    tick();
    bus.idata  = 16'sd60;
    tick();
    idle_bus();
    irst_n = 1'b0;
    tick();
    irst_n = 1'b1;
    check("rst_acc_ovalid", bus.ovalid, 0);
    check("rst_acc_ordy", bus.ordy, 1);
    tick();
    check("rst_acc_ovalid2", bus.ovalid, 0);
    set_group(24'sd0, 4'd0, 1, 0, 1'b0);
    g_beats[0] = 16'sd5;
    run_group();

    // Reset while a result is pending drops it.
    bus.ivalid = 1'b1; bus.ilast = 1'b1; bus.idata = 16'sd40;
    tick();
    idle_bus();
    tick();
    check("pend_ovalid", bus.ovalid, 1);
    irst_n = 1'b0;
    tick();
    irst_n = 1'b1;
    check("rst_out_ovalid", bus.ovalid, 0);
    check("rst_out_odata", bus.odata, 0);
    check("rst_out_ordy", bus.ordy, 1);
    tick();

    for (int k = 0; k < 60; k++) begin
      set_group($urandom_range(0, 3) == 0 ? 24'($urandom) : 24'($signed(12'($urandom))),
                4'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                1'($urandom));
      for (int i = 0; i < 8; i++) begin
        g_beats[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                 : 16'($signed(10'($urandom)));
      end
      run_group();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
